// File: rtl/rv32v_types_pkg.sv
// Shared RV32V vector types: element width, element offsets, sequencer state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32v_types_pkg;

  // Register file lane count and vl counter width used across the pipeline.
  localparam int NUM_LANES = 2;
  localparam int VL_WIDTH  = 7;

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2,
    SEW_64 = 2'd3
  } sew_t;

  // Element index; one bit wider than VL_WIDTH so vl = 2^(VL_WIDTH+1)-1 fits.
  typedef logic [VL_WIDTH:0] offset_t;

  typedef enum logic [0:0] {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/rv32v_element_sequencer_if.sv
// Decode/execute-facing bundle of the element sequencer.
// Latency: n/a (wiring only).
// Backpressure: beat_valid/beat_ready handshake toward execute; start/busy toward decode.
interface rv32v_element_sequencer_if
  import rv32v_types_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int VL_WIDTH  = 7
) ();

  // Decode side
  logic                  start;
  logic [4:0]            vs1_in;
  logic [4:0]            vs2_in;
  logic [4:0]            vs3_in;
  logic [4:0]            vd_in;
  logic [VL_WIDTH:0]     vl_in;
  sew_t                  sew_in;
  logic                  busy;

  // Register file / pipeline side
  logic [4:0]            vs1;
  logic [4:0]            vs2;
  logic [4:0]            vs3;
  logic [4:0]            vd;
  logic [VL_WIDTH:0]     vs1_offset;
  logic [VL_WIDTH:0]     vs2_offset;
  logic [VL_WIDTH:0]     vs3_offset;
  logic [VL_WIDTH:0]     vd_offset;
  sew_t                  sew;
  logic [VL_WIDTH:0]     vl;
  logic [NUM_LANES-1:0]  lane_active;
  logic                  beat_valid;
  logic                  beat_ready;
  logic                  first_beat;
  logic                  last_beat;
  logic                  done;

  // Sequencer side
  modport master (
    input  start, vs1_in, vs2_in, vs3_in, vd_in, vl_in, sew_in, beat_ready,
    output busy, vs1, vs2, vs3, vd, vs1_offset, vs2_offset, vs3_offset, vd_offset,
           sew, vl, lane_active, beat_valid, first_beat, last_beat, done
  );

  // Decode + execute side
  modport slave (
    output start, vs1_in, vs2_in, vs3_in, vd_in, vl_in, sew_in, beat_ready,
    input  busy, vs1, vs2, vs3, vd, vs1_offset, vs2_offset, vs3_offset, vd_offset,
           sew, vl, lane_active, beat_valid, first_beat, last_beat, done
  );

endinterface

// File: rtl/rv32v_element_sequencer.sv
// Steps one latched vector instruction through its vl elements, NUM_LANES per beat.
// Latency: start accepted at edge N -> first beat valid in cycle N+1; one beat/cycle.
// Backpressure: beat held stable while beat_ready=0; start ignored while busy.
module rv32v_element_sequencer
  import rv32v_types_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int VL_WIDTH  = 7
) (
  input logic                       CLK,
  input logic                       nRST,
  rv32v_element_sequencer_if.master sif
);

  localparam int OW = VL_WIDTH + 1;   // offset / vl width
  localparam int WW = VL_WIDTH + 2;   // widened compare width, cannot wrap
  localparam logic [WW-1:0] LANES_W = WW'(NUM_LANES);

  seq_state_t     state_q, state_d;
  logic [OW-1:0]  offset_q, offset_d;
  logic           done_q, done_d;

  logic [4:0]     vs1_q, vs2_q, vs3_q, vd_q;
  logic [OW-1:0]  vl_q;
  sew_t           sew_q;

  logic           run;
  logic           load;
  logic           xfer;
  logic           last;
  logic [WW-1:0]  offset_w;
  logic [WW-1:0]  next_off_w;
  logic [WW-1:0]  vl_w;
  logic [NUM_LANES-1:0] lane_act;

  assign run        = (state_q == SEQ_RUN);
  assign load       = !run && sif.start && (sif.vl_in != '0);
  assign offset_w   = {1'b0, offset_q};
  assign vl_w       = {1'b0, vl_q};
  assign next_off_w = offset_w + LANES_W;
  assign last       = run && (next_off_w >= vl_w);
  assign xfer       = run && sif.beat_ready;

  // Per-lane element-in-range flags, widened so offset+i never wraps.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_act[i] = run && ((offset_w + WW'(i)) < vl_w);
  end

  // Next-state: accept in IDLE, advance offset on each transferred beat.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    done_d   = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (sif.start) begin
          if (sif.vl_in != '0) begin
            state_d  = SEQ_RUN;
            offset_d = '0;
          end else begin
            // Empty instruction: acknowledge with a registered done pulse only.
            done_d = 1'b1;
          end
        end
      end
      SEQ_RUN: begin
        if (xfer) begin
          if (last) begin
            state_d = SEQ_IDLE;
          end else begin
            offset_d = next_off_w[OW-1:0];
          end
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= SEQ_IDLE;
      offset_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      done_q   <= done_d;
    end
  end

  // Instruction fields, captured only when a non-empty instruction is accepted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      vs1_q <= '0;
      vs2_q <= '0;
      vs3_q <= '0;
      vd_q  <= '0;
      vl_q  <= '0;
      sew_q <= SEW_8;
    end else if (load) begin
      vs1_q <= sif.vs1_in;
      vs2_q <= sif.vs2_in;
      vs3_q <= sif.vs3_in;
      vd_q  <= sif.vd_in;
      vl_q  <= sif.vl_in;
      sew_q <= sif.sew_in;
    end
  end

  assign sif.busy        = run;
  assign sif.beat_valid  = run;
  assign sif.vs1         = vs1_q;
  assign sif.vs2         = vs2_q;
  assign sif.vs3         = vs3_q;
  assign sif.vd          = vd_q;
  assign sif.vl          = vl_q;
  assign sif.sew         = sew_q;
  assign sif.vs1_offset  = offset_q;
  assign sif.vs2_offset  = offset_q;
  assign sif.vs3_offset  = offset_q;
  assign sif.vd_offset   = offset_q;
  assign sif.lane_active = lane_act;
  assign sif.first_beat  = run && (offset_q == '0);
  assign sif.last_beat   = last;
  // Final-beat done is combinational with the handshake; empty-vl done is registered.
  assign sif.done        = done_q || (xfer && last);

endmodule

// File: tb/tb_rv32v_element_sequencer.sv
// Directed bench for rv32v_element_sequencer with NUM_LANES=2, VL_WIDTH=7.
// Latency: drives inputs 1 time unit after posedge, samples on negedge.
// Backpressure: exercises beat_ready stalls and start-while-busy.
module tb_rv32v_element_sequencer;
  import rv32v_types_pkg::*;

  logic CLK;
  logic nRST;

  int n_vec;
  int n_err;
  int xfer_cnt;
  int done_cnt;
  int valid_cnt;

  rv32v_element_sequencer_if #(.NUM_LANES(NUM_LANES), .VL_WIDTH(VL_WIDTH)) sif ();

  rv32v_element_sequencer #(.NUM_LANES(NUM_LANES), .VL_WIDTH(VL_WIDTH)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .sif  (sif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Independent event counters sampled mid-cycle.
  always @(negedge CLK) begin
    if (sif.beat_valid && sif.beat_ready) xfer_cnt <= xfer_cnt + 1;
    if (sif.done)                         done_cnt <= done_cnt + 1;
    if (sif.beat_valid)                   valid_cnt <= valid_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic smp;
    @(negedge CLK);
  endtask

  // Present one instruction for one accepting edge, then drop start.
  task automatic issue(input logic [4:0] v1, input logic [7:0] vl_v, input sew_t s);
    sif.start  = 1'b1;
    sif.vs1_in = v1;
    sif.vs2_in = v1 + 5'd1;
    sif.vs3_in = v1 + 5'd2;
    sif.vd_in  = v1 + 5'd3;
    sif.vl_in  = vl_v;
    sif.sew_in = s;
    tick();
    sif.start  = 1'b0;
  endtask

  task automatic chk_beat(input string tag, input int off, input int lanes,
                          input bit f, input bit l, input bit d);
    chk({tag, ".valid"}, 32'(sif.beat_valid), 32'd1);
    chk({tag, ".busy"},  32'(sif.busy),       32'd1);
    chk({tag, ".off1"},  32'(sif.vs1_offset), off);
    chk({tag, ".off2"},  32'(sif.vs2_offset), off);
    chk({tag, ".off3"},  32'(sif.vs3_offset), off);
    chk({tag, ".offd"},  32'(sif.vd_offset),  off);
    chk({tag, ".lanes"}, 32'(sif.lane_active), lanes);
    chk({tag, ".first"}, 32'(sif.first_beat), 32'(f));
    chk({tag, ".last"},  32'(sif.last_beat),  32'(l));
    chk({tag, ".done"},  32'(sif.done),       32'(d));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"},  32'(sif.busy),        32'd0);
    chk({tag, ".valid"}, 32'(sif.beat_valid),  32'd0);
    chk({tag, ".lanes"}, 32'(sif.lane_active), 32'd0);
    chk({tag, ".first"}, 32'(sif.first_beat),  32'd0);
    chk({tag, ".last"},  32'(sif.last_beat),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0, d0, v0, k;
    bit seen;
    n_vec = 0; n_err = 0;
    xfer_cnt = 0; done_cnt = 0; valid_cnt = 0;
    nRST = 1'b0;
    sif.start = 1'b0; sif.vs1_in = '0; sif.vs2_in = '0; sif.vs3_in = '0;
    sif.vd_in = '0; sif.vl_in = '0; sif.sew_in = SEW_8; sif.beat_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    // Reset state
    smp();
    chk_idle("rst");
    chk("rst.done", 32'(sif.done), 32'd0);
    chk("rst.vs1",  32'(sif.vs1),  32'd0);
    chk("rst.vl",   32'(sif.vl),   32'd0);
    chk("rst.off",  32'(sif.vs1_offset), 32'd0);

    // vl=5, ready held: offsets 0,2,4 lanes 11,11,01
    sif.beat_ready = 1'b1;
    issue(5'd3, 8'd5, SEW_32);
    smp();
    chk_beat("v5b0", 0, 3, 1, 0, 0);
    chk("v5.vs1", 32'(sif.vs1), 32'd3);
    chk("v5.vs2", 32'(sif.vs2), 32'd4);
    chk("v5.vs3", 32'(sif.vs3), 32'd5);
    chk("v5.vd",  32'(sif.vd),  32'd6);
    chk("v5.vl",  32'(sif.vl),  32'd5);
    chk("v5.sew", 32'(sif.sew), 32'(SEW_32));
    tick(); smp();
    chk_beat("v5b1", 2, 3, 0, 0, 0);
    tick(); smp();
    chk_beat("v5b2", 4, 1, 0, 1, 1);
    tick(); smp();
    chk_idle("v5end");
    chk("v5end.done", 32'(sif.done), 32'd0);

    // vl=4 with a 3-cycle stall on the second beat
    x0 = xfer_cnt;
    issue(5'd10, 8'd4, SEW_16);
    smp();
    chk_beat("v4b0", 0, 3, 1, 0, 0);
    tick();
    sif.beat_ready = 1'b0;
    smp();
    chk_beat("v4s0", 2, 3, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      tick(); smp();
      chk_beat("v4s", 2, 3, 0, 1, 0);
      chk("v4s.vs1", 32'(sif.vs1), 32'd10);
    end
    tick();
    sif.beat_ready = 1'b1;
    smp();
    chk_beat("v4b1", 2, 3, 0, 1, 1);
    tick(); smp();
    chk_idle("v4end");
    tick();
    chk("v4.xfers", 32'(xfer_cnt - x0), 32'd2);

    // vl=0: done one cycle after start, never busy or valid
    v0 = valid_cnt; d0 = done_cnt;
    smp();
    chk("v0.pre_done", 32'(sif.done), 32'd0);
    issue(5'd1, 8'd0, SEW_8);
    smp();
    chk("v0.done", 32'(sif.done), 32'd1);
    chk_idle("v0");
    tick(); smp();
    chk("v0.done_off", 32'(sif.done), 32'd0);
    chk("v0.busy2",    32'(sif.busy), 32'd0);
    tick();
    chk("v0.valids", 32'(valid_cnt - v0), 32'd0);
    chk("v0.dones",  32'(done_cnt - d0),  32'd1);

    // start during RUN is ignored
    smp();
    issue(5'd3, 8'd4, SEW_8);
    sif.start = 1'b1; sif.vs1_in = 5'd9; sif.vl_in = 8'd6;
    smp();
    chk_beat("ign.b0", 0, 3, 1, 0, 0);
    chk("ign.vs1a", 32'(sif.vs1), 32'd3);
    tick(); smp();
    chk_beat("ign.b1", 2, 3, 0, 1, 1);
    chk("ign.vs1b", 32'(sif.vs1), 32'd3);
    chk("ign.vl",   32'(sif.vl),  32'd4);
    tick();
    sif.start = 1'b0;
    smp();
    chk_idle("ign.end");
    chk("ign.vs1c", 32'(sif.vs1), 32'd3);
    tick(); smp();
    chk("ign.busy", 32'(sif.busy), 32'd0);

    // Reset at the second beat of vl=8, then a fresh vl=1
    issue(5'd7, 8'd8, SEW_64);
    smp();
    chk_beat("r8.b0", 0, 3, 1, 0, 0);
    tick();
    d0 = done_cnt;
    #2 nRST = 1'b0;
    #1;
    chk_idle("r8.async");
    chk("r8.done", 32'(sif.done),       32'd0);
    chk("r8.off",  32'(sif.vs1_offset), 32'd0);
    chk("r8.vs1",  32'(sif.vs1),        32'd0);
    chk("r8.vl",   32'(sif.vl),         32'd0);
    chk("r8.sew",  32'(sif.sew),        32'd0);
    smp();
    chk("r8.done2", 32'(sif.done), 32'd0);
    tick();
    nRST = 1'b1;
    smp();
    chk_idle("r8.rel");
    issue(5'd2, 8'd1, SEW_8);
    smp();
    chk_beat("r1.b0", 0, 1, 1, 1, 1);
    tick(); smp();
    chk_idle("r1.end");
    tick();
    chk("r8.dones", 32'(done_cnt - d0), 32'd1);

    // vl=255: 128 beats, last at offset 254 with lanes 01, no wrap
    smp();
    issue(5'd4, 8'd255, SEW_8);
    k = 0;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      smp();
      if (sif.beat_valid) begin
        chk("big.off", 32'(sif.vs1_offset), 32'(2 * k));
        if (sif.last_beat) begin
          chk("big.lastoff",   32'(sif.vs1_offset),  32'd254);
          chk("big.lastlanes", 32'(sif.lane_active), 32'd1);
          chk("big.done",      32'(sif.done),        32'd1);
          seen = 1'b1;
        end else begin
          chk("big.lanes", 32'(sif.lane_active), 32'd3);
        end
        k++;
      end
      tick();
    end
    chk("big.beats", 32'(k), 32'd128);
    smp();
    chk_idle("big.end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
